// File: rtl/bq_bandpass_mc_pkg.sv
// bq_pkg: FSM states, tap indices and the round/saturate helper shared by the
// bq_bandpass_mc datapath.
package bq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_OUT} bq_state_e;
  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;
  localparam int COEF_W_DEF = 18;
  localparam int COEF_ONE = 1 << (COEF_W_DEF - 2);
  function automatic int coef_one(input int cw);
    return 1 << (cw - 2);
  endfunction
  // Round half up, drop the Q fraction bits, then clip to a dw-bit signed range.
  function automatic logic signed [63:0] rnd_sat(input logic signed [63:0] v, input int sh,
                                                  input int dw, output logic clip);
    logic signed [63:0] r, hi, lo;
    r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    clip = r > hi || r < lo;
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/bq_bandpass_mc_mac.sv
// bq_mac: signed multiplier feeding an accumulator with restart and add/subtract select.
module bq_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int ACC_W = DATA_W + COEF_W + 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  logic sub_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [COEF_W-1:0] b_i,
  output logic signed [ACC_W-1:0] acc_o
);
  logic signed [ACC_W-1:0] acc_q, acc_d, p;
  always_comb begin
    p = ACC_W'(a_i) * ACC_W'(b_i);
    acc_d = (clr_i ? '0 : acc_q) + (sub_i ? -p : p);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/bq_bandpass_mc.sv
// bq_bandpass_mc: multi-channel cascaded direct-form-I biquads sharing one MAC.
// Define BQ_SAT_CNT_EN to add the saturating sat_cnt clip counter output.
module bq_bandpass_mc
  import bq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int NUM_CH = 2,
  parameter int NUM_STAGES = 2,
  parameter int ACC_W = DATA_W + COEF_W + 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [$clog2(NUM_CH)-1:0] in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [DATA_W-1:0] out_data,
  input  logic cfg_we,
  input  logic [$clog2(NUM_STAGES*5)-1:0] cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata,
  output logic cfg_busy,
  input  logic state_clr,
`ifdef BQ_SAT_CNT_EN
  output logic [15:0] sat_cnt,
`endif
  output logic sat_flag
);
  localparam int CW = $clog2(NUM_CH);
  localparam int SW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam int AW = $clog2(NUM_STAGES * 5);
  localparam int LAST = NUM_STAGES - 1;
  localparam logic [COEF_W-1:0] ONE = COEF_W'(coef_one(COEF_W));
  bq_state_e state_q, state_d;
  logic [2:0] tap_q;
  logic [SW-1:0] stg_q;
  logic [CW-1:0] ch_q, out_ch_q;
  logic signed [DATA_W-1:0] x_q, out_data_q;
  logic sat_q;
  logic [COEF_W-1:0] coef_q [NUM_STAGES*5];
  logic signed [DATA_W-1:0] x1_q [NUM_CH][NUM_STAGES];
  logic signed [DATA_W-1:0] x2_q [NUM_CH][NUM_STAGES];
  logic signed [DATA_W-1:0] y1_q [NUM_CH][NUM_STAGES];
  logic signed [DATA_W-1:0] y2_q [NUM_CH][NUM_STAGES];
  logic [AW-1:0] cidx;
  logic signed [DATA_W-1:0] opnd, y;
  logic signed [63:0] y64;
  logic signed [ACC_W-1:0] acc;
  logic clip;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // Out-of-range channels are consumed in IDLE without leaving it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid && 32'(in_ch) < NUM_CH) state_d = S_MAC;
      S_MAC:   if (tap_q == TAP_A2) state_d = S_STORE;
      S_STORE: state_d = 32'(stg_q) == LAST ? S_OUT : S_MAC;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_clr) state_d = S_IDLE;
  end
  always_comb begin
    in_ready = state_q == S_IDLE;
    cfg_busy = state_q != S_IDLE;
    out_valid = state_q == S_OUT;
  end
  always_comb begin
    cidx = AW'(stg_q) * AW'(5) + AW'(tap_q);
    opnd = tap_q == TAP_B0 ? x_q :
           tap_q == TAP_B1 ? x1_q[ch_q][stg_q] :
           tap_q == TAP_B2 ? x2_q[ch_q][stg_q] :
           tap_q == TAP_A1 ? y1_q[ch_q][stg_q] : y2_q[ch_q][stg_q];
    y64 = rnd_sat(64'(acc), COEF_W - 2, DATA_W, clip);
    y = DATA_W'(y64);
  end
  bq_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == S_MAC),
    .clr_i (tap_q == TAP_B0),
    .sub_i (tap_q >= TAP_A1),
    .a_i   (opnd),
    .b_i   ($signed(coef_q[cidx])),
    .acc_o (acc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NUM_STAGES * 5; i++) coef_q[i] <= i % 5 == 0 ? ONE : '0;
    else if (cfg_we && !cfg_busy && 32'(cfg_addr) < NUM_STAGES * 5) coef_q[cfg_addr] <= cfg_wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q <= '{default: '0};
      x2_q <= '{default: '0};
      y1_q <= '{default: '0};
      y2_q <= '{default: '0};
    end else if (state_clr) begin
      x1_q <= '{default: '0};
      x2_q <= '{default: '0};
      y1_q <= '{default: '0};
      y2_q <= '{default: '0};
    end else if (state_q == S_STORE) begin
      x2_q[ch_q][stg_q] <= x1_q[ch_q][stg_q];
      x1_q[ch_q][stg_q] <= x_q;
      y2_q[ch_q][stg_q] <= y1_q[ch_q][stg_q];
      y1_q[ch_q][stg_q] <= y;
    end
  end
  // Each stage's rounded output becomes the next stage's input in x_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q <= '0;
      stg_q <= '0;
      ch_q <= '0;
      x_q <= '0;
      out_ch_q <= '0;
      out_data_q <= '0;
      sat_q <= 1'b0;
    end else begin
      tap_q <= state_q == S_MAC ? tap_q + 3'd1 : '0;
      if (state_q == S_IDLE) begin
        ch_q <= in_ch;
        x_q <= $signed(in_data);
        stg_q <= '0;
      end
      if (state_q == S_STORE) begin
        x_q <= y;
        stg_q <= stg_q + SW'(1);
      end
      if (state_q == S_STORE && 32'(stg_q) == LAST) begin
        out_ch_q <= ch_q;
        out_data_q <= y;
      end
      sat_q <= !state_clr && (sat_q || (state_q == S_STORE && clip));
    end
  end
  assign out_ch = out_ch_q;
  assign out_data = out_data_q;
  assign sat_flag = sat_q;
`ifdef BQ_SAT_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (state_clr) cnt_q <= '0;
    else if (state_q == S_STORE && clip && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign sat_cnt = cnt_q;
`endif
endmodule
